// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, flit type codes and default widths
// used by the router datapath blocks.
package noc_pkg;

    localparam int NOC_TYPE_W    = 3;
    localparam int NOC_PAYLOAD_W = 64;
    localparam int NOC_DATA_W    = NOC_TYPE_W + NOC_PAYLOAD_W;
    localparam int NOC_VCH_W     = 2;
    localparam int NOC_PORT_CNT  = 5;
    localparam int NOC_SEL_W     = NOC_PORT_CNT;

    typedef enum logic [NOC_TYPE_W-1:0] {
        TYPE_NONE = 3'd0,
        TYPE_HEAD = 3'd1,
        TYPE_DATA = 3'd2,
        TYPE_TAIL = 3'd3
    } flit_type_t;

    // Resolved port pick: exactly one member is set.
    typedef struct packed {
        logic pick0;
        logic pick1;
        logic none;
    } sel_dec_t;

    // Builds a flit with the type code in the MSBs above the payload.
    function automatic logic [NOC_DATA_W-1:0] make_flit(input flit_type_t ftype,
                                                        input logic [NOC_PAYLOAD_W-1:0] payload);
        return {ftype, payload};
    endfunction

endpackage

// File: rtl/noc_mux2_sel.sv
// Select decoder for the 2:1 flit mux: resolves the one-hot router port
// select into a single pick, with port 0 winning when both low bits are set.
// Bits above [1:0] address other router ports and do not affect this mux.
module noc_mux2_sel
    import noc_pkg::*;
#(
    parameter int SEL_W = NOC_SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    output sel_dec_t         dec
);

    // Priority resolve: port 0 over port 1, otherwise nothing selected.
    always_comb begin
        dec = '0;
        if (sel[0]) begin
            dec.pick0 = 1'b1;
        end else if (sel[1]) begin
            dec.pick1 = 1'b1;
        end else begin
            dec.none = 1'b1;
        end
    end

    // Upper select bits are consumed here only so they do not dangle.
    if (SEL_W > 2) begin : g_upper
        logic sel_upper_unused;
        assign sel_upper_unused = |sel[SEL_W-1:2];
    end

endmodule

// File: rtl/noc_mux2.sv
// 2:1 NoC flit multiplexer with a registered output (one cycle latency).
// Steers data, valid and VC id of the selected port to the output port.
// Build option NOC_MUX2_IDLE_GATE_EN: when the selected port is not valid
// (or no port is selected) odata/ovch hold their previous value and only
// ovalid drops, so the wide data register does not toggle while idle.
module noc_mux2
    import noc_pkg::*;
#(
    parameter int DATA_W = NOC_DATA_W,
    parameter int VCH_W  = NOC_VCH_W,
    parameter int SEL_W  = NOC_SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] idata_0,
    input  logic              ivalid_0,
    input  logic [VCH_W-1:0]  ivch_0,
    input  logic [DATA_W-1:0] idata_1,
    input  logic              ivalid_1,
    input  logic [VCH_W-1:0]  ivch_1,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    output logic [VCH_W-1:0]  ovch
);

    sel_dec_t          sel_dec;
    logic [DATA_W-1:0] data_nxt;
    logic              valid_nxt;
    logic [VCH_W-1:0]  vch_nxt;

    noc_mux2_sel #(
        .SEL_W (SEL_W)
    ) u_sel (
        .sel (sel),
        .dec (sel_dec)
    );

    // Steer the picked port; an unselected output is all zero.
    always_comb begin
        data_nxt  = '0;
        valid_nxt = 1'b0;
        vch_nxt   = '0;
        if (!sel_dec.none) begin
            if (sel_dec.pick0) begin
                data_nxt  = idata_0;
                valid_nxt = ivalid_0;
                vch_nxt   = ivch_0;
            end else begin
                data_nxt  = idata_1;
                valid_nxt = ivalid_1;
                vch_nxt   = ivch_1;
            end
        end
    end

    // Output register; reset clears it, nothing else holds state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            odata  <= '0;
            ovalid <= 1'b0;
            ovch   <= '0;
        end else begin
            ovalid <= valid_nxt;
`ifdef NOC_MUX2_IDLE_GATE_EN
            if (valid_nxt) begin
                odata <= data_nxt;
                ovch  <= vch_nxt;
            end
`else
            odata <= data_nxt;
            ovch  <= vch_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_noc_mux2.sv
// Self-checking bench for noc_mux2. Expected outputs are computed from the
// driven inputs by a behavioural model and queued; each test pops and
// compares them one cycle later. Honours NOC_MUX2_IDLE_GATE_EN.
module tb_noc_mux2;
    import noc_pkg::*;

    localparam int DW = NOC_DATA_W;
    localparam int VW = NOC_VCH_W;
    localparam int SW = NOC_SEL_W;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          v;
        logic [VW-1:0] c;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] idata_0, idata_1, odata;
    logic          ivalid_0, ivalid_1, ovalid;
    logic [VW-1:0] ivch_0, ivch_1, ovch;
    logic [SW-1:0] sel;

    exp_t          sb_q[$];
    exp_t          e;
    logic [DW-1:0] m_data;
    logic [VW-1:0] m_vch;
    int            n_checks = 0;
    int            n_fail   = 0;

    noc_mux2 dut (
        .clk      (clk),
        .rst      (rst),
        .idata_0  (idata_0),
        .ivalid_0 (ivalid_0),
        .ivch_0   (ivch_0),
        .idata_1  (idata_1),
        .ivalid_1 (ivalid_1),
        .ivch_1   (ivch_1),
        .sel      (sel),
        .odata    (odata),
        .ovalid   (ovalid),
        .ovch     (ovch)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rand_flit();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    // Drive one cycle of inputs and queue the output they should produce.
    task automatic drive(input logic [DW-1:0] d0, input logic v0, input logic [VW-1:0] c0,
                         input logic [DW-1:0] d1, input logic v1, input logic [VW-1:0] c1,
                         input logic [SW-1:0] s);
        exp_t x;
        logic [DW-1:0] cd;
        logic [VW-1:0] cc;
        idata_0 = d0; ivalid_0 = v0; ivch_0 = c0;
        idata_1 = d1; ivalid_1 = v1; ivch_1 = c1;
        sel = s;
        cd = '0; cc = '0; x.v = 1'b0;
        if (s[0]) begin
            cd = d0; cc = c0; x.v = v0;
        end else if (s[1]) begin
            cd = d1; cc = c1; x.v = v1;
        end
`ifdef NOC_MUX2_IDLE_GATE_EN
        if (x.v) begin
            m_data = cd; m_vch = cc;
        end
`else
        m_data = cd; m_vch = cc;
`endif
        x.d = m_data;
        x.c = m_vch;
        sb_q.push_back(x);
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_data = '0;
        m_vch  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        idata_0 = rand_flit(); ivalid_0 = 1'b1; ivch_0 = 2'd3;
        idata_1 = rand_flit(); ivalid_1 = 1'b1; ivch_1 = 2'd2;
        sel = 5'b00010;
        #2;
        n_checks++;
        if ({odata, ovalid, ovch} !== '0) begin
            n_fail++;
            $display("FAIL reset_immediate: got %h/%b/%h want 0/0/0", odata, ovalid, ovch);
        end
        for (int i = 0; i < 4; i++) begin
            idata_0 = rand_flit(); idata_1 = rand_flit();
            ivch_0 = VW'($urandom()); ivch_1 = VW'($urandom());
            @(posedge clk); #1;
            n_checks++;
            if ({odata, ovalid, ovch} !== '0) begin
                n_fail++;
                $display("FAIL reset_held[%0d]: got %h/%b/%h want 0/0/0", i, odata, ovalid, ovch);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_port1();
        drive(rand_flit(), 1'b1, 2'd3, 67'h2_0000_0000_0000_0004, 1'b1, 2'd1, 5'b00010);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_checks++;
        if ({odata, ovalid, ovch} !== {67'h2_0000_0000_0000_0004, 1'b1, 2'd1} || e !== {odata, ovalid, ovch}) begin
            n_fail++;
            $display("FAIL port1_single: got %h/%b/%h want %h/%b/%h", odata, ovalid, ovch, e.d, e.v, e.c);
        end
    endtask

    task automatic test_port0_head();
        logic [DW-1:0] head;
        logic [DW-1:0] other;
        head = make_flit(TYPE_HEAD, {32'h0, 32'h09});
        for (int i = 0; i < 3; i++) begin
            other = rand_flit();
            drive(head, 1'b1, 2'd2, other, 1'b1, 2'd1, 5'b00001);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({odata, ovalid, ovch} !== e || odata === other) begin
                n_fail++;
                $display("FAIL port0_head[%0d]: got %h/%b/%h want %h/%b/%h", i, odata, ovalid, ovch, e.d, e.v, e.c);
            end
        end
    endtask

    task automatic test_priority_and_idle();
        logic [DW-1:0] f0;
        f0 = make_flit(TYPE_DATA, 64'hA5A5_0000_1111_2222);
        drive(f0, 1'b1, 2'd0, make_flit(TYPE_DATA, 64'h5A5A_FFFF_3333_4444), 1'b1, 2'd3, 5'b00011);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_checks++;
        if ({odata, ovalid, ovch} !== e || odata !== f0) begin
            n_fail++;
            $display("FAIL both_selected: got %h/%b/%h want %h/%b/%h", odata, ovalid, ovch, e.d, e.v, e.c);
        end
        drive(rand_flit(), 1'b1, 2'd1, rand_flit(), 1'b1, 2'd2, 5'b00000);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_checks++;
        if ({odata, ovalid, ovch} !== e || ovalid !== 1'b0) begin
            n_fail++;
            $display("FAIL none_selected: got %h/%b/%h want %h/%b/%h", odata, ovalid, ovch, e.d, e.v, e.c);
        end
        drive(rand_flit(), 1'b1, 2'd1, rand_flit(), 1'b0, 2'd2, 5'b11100);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_checks++;
        if ({odata, ovalid, ovch} !== e) begin
            n_fail++;
            $display("FAIL upper_sel_ignored: got %h/%b/%h want %h/%b/%h", odata, ovalid, ovch, e.d, e.v, e.c);
        end
    endtask

    task automatic test_packet_stream();
        logic [63:0] one;
        int          nvalid;
        one = 64'h1;
        nvalid = 0;
        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < 29; k++) begin
                logic [DW-1:0] f;
                logic          v;
                if (k == 0)       begin f = make_flit(TYPE_HEAD, 64'(p)); v = 1'b1; end
                else if (k <= 20) begin f = make_flit(TYPE_DATA, one << ((p * 20 + k - 1) % 64)); v = 1'b1; end
                else if (k == 21) begin f = make_flit(TYPE_TAIL, 64'hDEAD_0000 + 64'(p)); v = 1'b1; end
                else              begin f = rand_flit(); v = 1'b0; end
                drive(rand_flit(), 1'b1, 2'd0, f, v, VW'(p), 5'b00010);
                @(posedge clk); #1;
                e = sb_q.pop_front();
                n_checks++;
                if ({odata, ovalid, ovch} !== e) begin
                    n_fail++;
                    $display("FAIL stream p%0d k%0d: got %h/%b/%h want %h/%b/%h", p, k, odata, ovalid, ovch, e.d, e.v, e.c);
                end
                if (ovalid === 1'b1) nvalid++;
            end
        end
        n_checks++;
        if (nvalid !== 220) begin
            n_fail++;
            $display("FAIL stream_flit_count: got %0d want 220", nvalid);
        end
    endtask

    task automatic test_random_sel();
        for (int i = 0; i < 60; i++) begin
            drive(rand_flit(), 1'($urandom()), VW'($urandom()), rand_flit(), 1'($urandom()), VW'($urandom()),
                  SW'($urandom()));
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({odata, ovalid, ovch} !== e) begin
                n_fail++;
                $display("FAIL random_sel[%0d]: got %h/%b/%h want %h/%b/%h", i, odata, ovalid, ovch, e.d, e.v, e.c);
            end
        end
    endtask

    task automatic test_idle_data();
        logic [DW-1:0] last;
        last = make_flit(TYPE_TAIL, 64'h0123_4567_89AB_CDEF);
        drive(rand_flit(), 1'b0, 2'd0, last, 1'b1, 2'd2, 5'b00010);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_checks++;
        if ({odata, ovalid, ovch} !== e) begin
            n_fail++;
            $display("FAIL idle_last_flit: got %h/%b/%h want %h/%b/%h", odata, ovalid, ovch, e.d, e.v, e.c);
        end
        for (int i = 0; i < 5; i++) begin
            logic [DW-1:0] f;
            f = rand_flit();
            drive(rand_flit(), 1'b1, 2'd1, f, 1'b0, 2'd3, 5'b00010);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
`ifdef NOC_MUX2_IDLE_GATE_EN
            if ({odata, ovalid, ovch} !== e || odata !== last || ovch !== 2'd2) begin
`else
            if ({odata, ovalid, ovch} !== e || odata !== f || ovch !== 2'd3) begin
`endif
                n_fail++;
                $display("FAIL idle_data[%0d]: got %h/%b/%h want %h/%b/%h", i, odata, ovalid, ovch, e.d, e.v, e.c);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(make_flit(TYPE_DATA, 64'hFFFF_0000_FFFF_0000), 1'b1, 2'd3, rand_flit(), 1'b1, 2'd1, 5'b00001);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_checks++;
        if ({odata, ovalid, ovch} !== e) begin
            n_fail++;
            $display("FAIL pre_reset: got %h/%b/%h want %h/%b/%h", odata, ovalid, ovch, e.d, e.v, e.c);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({odata, ovalid, ovch} !== '0) begin
            n_fail++;
            $display("FAIL reset_async_midstream: got %h/%b/%h want 0/0/0", odata, ovalid, ovch);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        drive(rand_flit(), 1'b0, 2'd3, rand_flit(), 1'b1, 2'd1, 5'b00001);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_checks++;
        if ({odata, ovalid, ovch} !== e) begin
            n_fail++;
            $display("FAIL post_reset: got %h/%b/%h want %h/%b/%h", odata, ovalid, ovch, e.d, e.v, e.c);
        end
    endtask

    initial begin
        m_data = '0;
        m_vch  = '0;
        test_reset();
        test_port1();
        test_port0_head();
        test_priority_and_idle();
        test_packet_stream();
        test_random_sel();
        test_idle_data();
        test_reset_midstream();
        n_checks++;
        if (sb_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
